// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed HH-MM-SS scanner: segment patterns, slot map, blink bits.
// Pure definitions with no logic, so there is no latency and no backpressure.
package clock_disp_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] AN_OFF = 8'hFF;

  // Slot 0 is the rightmost digit
  localparam logic [2:0] SLOT_SEC_O  = 3'd0;
  localparam logic [2:0] SLOT_SEC_T  = 3'd1;
  localparam logic [2:0] SLOT_DASH_L = 3'd2;
  localparam logic [2:0] SLOT_MIN_O  = 3'd3;
  localparam logic [2:0] SLOT_MIN_T  = 3'd4;
  localparam logic [2:0] SLOT_DASH_H = 3'd5;
  localparam logic [2:0] SLOT_HOUR_O = 3'd6;
  localparam logic [2:0] SLOT_HOUR_T = 3'd7;

  localparam int BLINK_SEC  = 0;
  localparam int BLINK_MIN  = 1;
  localparam int BLINK_HOUR = 2;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } time_t;

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low 7-segment pattern; non-decimal nibbles show 'E'.
// Combinational, zero latency, no backpressure.
module seg7_decode
  import clock_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Eight-digit HH-MM-SS display scanner with per-frame snapshot, leading-zero and field blink.
// an/seg are registered one cycle after the slot index; free-running, no backpressure.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       en,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [2:0] blink_mask,
  output logic [7:0] an,
  output logic [6:0] seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  time_t         snap;

  logic          tick;
  logic          frame_wrap;
  logic [3:0]    nibble;
  logic          is_dash;
  logic          field_blink;
  logic          blank;
  logic [6:0]    dec_seg;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign tick       = (presc == PW'(SCAN_DIV - 1));
  assign frame_wrap = tick && (idx == SLOT_HOUR_T);

  always_comb begin
    nibble      = 4'd0;
    is_dash     = 1'b0;
    field_blink = 1'b0;
    case (idx)
      SLOT_SEC_O:  begin nibble = snap.sec[3:0];  field_blink = blink_mask[BLINK_SEC];  end
      SLOT_SEC_T:  begin nibble = snap.sec[7:4];  field_blink = blink_mask[BLINK_SEC];  end
      SLOT_MIN_O:  begin nibble = snap.min[3:0];  field_blink = blink_mask[BLINK_MIN];  end
      SLOT_MIN_T:  begin nibble = snap.min[7:4];  field_blink = blink_mask[BLINK_MIN];  end
      SLOT_HOUR_O: begin nibble = snap.hour[3:0]; field_blink = blink_mask[BLINK_HOUR]; end
      SLOT_HOUR_T: begin nibble = snap.hour[7:4]; field_blink = blink_mask[BLINK_HOUR]; end
      default:     is_dash = 1'b1;
    endcase
  end

  seg7_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Every blank cause yields the same pattern, so precedence collapses to one OR
  always_comb begin
    blank   = !en
           || (blink_phase && field_blink)
           || ((idx == SLOT_HOUR_T) && (snap.hour[7:4] == 4'd0));
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    if (!blank) begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = is_dash ? SEG_DASH : dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (cr) begin
      presc       <= '0;
      idx         <= SLOT_SEC_O;
      snap        <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      if (tick) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      // Snapshot only at frame boundaries so a frame never mixes two times
      if (frame_wrap) begin
        snap <= '{hour: hour, min: min, sec: sec};
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: arithmetic reference model checked every cycle plus literal expectations.
module tb_clock_display_scan;

  localparam int SD = 2;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       cr  = 1'b1;
  logic       en  = 1'b1;
  logic [7:0] hour = 8'h00;
  logic [7:0] min  = 8'h00;
  logic [7:0] sec  = 8'h00;
  logic [2:0] blink_mask = 3'b000;
  logic [7:0] an;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  always #5 clk = ~clk;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .cr         (cr),
    .en         (en),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg)
  );

  function automatic logic [6:0] pat(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d > 4'd9) ? 7'h06 : t[d];
  endfunction

  // m = clock edges since reset release; slot, frame and blink phase follow by division
  int          m;
  logic [23:0] msnap;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  bit          exp_vld = 0;

  task automatic model_out(input int mm, input logic [23:0] s, input logic en_i,
                           input logic [2:0] mask, output logic [7:0] a, output logic [6:0] g);
    int slot, frame, phase, field;
    logic [3:0] d [8];
    slot  = (mm / SD) % 8;
    frame = mm / (8 * SD);
    phase = (frame / BF) % 2;
    d[0] = s[3:0];   d[1] = s[7:4];   d[2] = 4'd0; d[3] = s[11:8];
    d[4] = s[15:12]; d[5] = 4'd0;     d[6] = s[19:16]; d[7] = s[23:20];
    field = (slot == 2 || slot == 5) ? -1 : slot / 3;
    if (!en_i || (phase == 1 && field >= 0 && mask[field]) || (slot == 7 && d[7] == 4'd0)) begin
      a = 8'hFF;
      g = 7'h7F;
    end else begin
      a = ~(8'd1 << slot);
      g = (field < 0) ? 7'h3F : pat(d[slot]);
    end
  endtask

  always @(posedge clk) begin
    if (cr) begin
      m = 0;
      msnap = 24'd0;
      exp_an = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      model_out(m, msnap, en, blink_mask, exp_an, exp_seg);
      m++;
      if (m % (8 * SD) == 0) msnap = {hour, min, sec};
    end
    exp_vld = 1;
  end

  always @(negedge clk) begin
    if (exp_vld) begin
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        failures++;
        $display("FAIL model e=%0d got an=%h seg=%h want an=%h seg=%h", e, an, seg, exp_an, exp_seg);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  task automatic chk(input string name, input logic [7:0] a, input logic [6:0] g);
    checks++;
    if (an !== a || seg !== g) begin
      failures++;
      $display("FAIL %s e=%0d got an=%h seg=%h want an=%h seg=%h", name, e, an, seg, a, g);
    end
  endtask

  logic [7:0] t_an  [8];
  logic [6:0] t_seg [8];

  initial begin
    // Reset held for two edges
    step(); step();
    chk("reset", 8'hFF, 7'h7F);
    cr = 1'b0; e = 0;
    hour = 8'h23; min = 8'h59; sec = 8'h58;
    step(); chk("release_slot0", 8'hFE, 7'h40);
    step(); chk("slot0_hold", 8'hFE, 7'h40);
    step(); chk("slot1_advance", 8'hFD, 7'h40);

    // Frame 1 shows 23:59:58 even though sec moves to 59 right after the snapshot
    run_to(16);
    sec = 8'h59;
    t_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    t_seg = '{7'h00, 7'h12, 7'h3F, 7'h10, 7'h12, 7'h3F, 7'h30, 7'h24};
    for (int i = 0; i < 8; i++) begin
      run_to(17 + 2 * i);
      chk($sformatf("snap_slot%0d", i), t_an[i], t_seg[i]);
    end
    run_to(33); chk("next_frame_s0", 8'hFE, 7'h10);

    // Leading zero and invalid nibble, visible in frame 3
    run_to(34);
    hour = 8'h07; min = 8'h5A;
    run_to(55); chk("invalid_min_ones", 8'hF7, 7'h06);
    run_to(57); chk("min_tens", 8'hEF, 7'h12);
    run_to(61); chk("hour_ones_7", 8'hBF, 7'h78);
    run_to(63); chk("leading_zero", 8'hFF, 7'h7F);

    // Fresh reset, minute field blinking
    cr = 1'b1;
    step(); step();
    chk("reset2", 8'hFF, 7'h7F);
    cr = 1'b0; e = 0;
    hour = 8'h12; min = 8'h34; sec = 8'h56; blink_mask = 3'b010;
    run_to(9); chk("blink_f0_visible", 8'hEF, 7'h40);
    run_to(23); chk("blink_f1_visible", 8'hF7, 7'h19);
    run_to(33); chk("blink_f2_sec_kept", 8'hFE, 7'h02);
    run_to(37); chk("blink_f2_dash_kept", 8'hFB, 7'h3F);
    run_to(39); chk("blink_f2_min_o", 8'hFF, 7'h7F);
    run_to(41); chk("blink_f2_min_t", 8'hFF, 7'h7F);
    run_to(55); chk("blink_f3_min_o", 8'hFF, 7'h7F);
    run_to(71); chk("blink_f4_min_o", 8'hF7, 7'h19);
    run_to(73); chk("blink_f4_min_t", 8'hEF, 7'h30);

    // Display enable drop mid-slot; scanning continues underneath
    run_to(80);
    en = 1'b0;
    step(); chk("en_off", 8'hFF, 7'h7F);
    run_to(83);
    en = 1'b1;
    step(); chk("en_on_slot1", 8'hFD, 7'h12);

    // Reset in slot 4 aborts the frame
    run_to(89); chk("pre_cr_slot4", 8'hEF, 7'h30);
    cr = 1'b1;
    step(); chk("cr_mid", 8'hFF, 7'h7F);
    cr = 1'b0; e = 0;
    step(); chk("cr_release_slot0", 8'hFE, 7'h40);
    run_to(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
